// File: rtl/audio_addr_pkg.sv
// Shared types and reset defaults for the audio sample address sequencer.
package audio_addr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam logic [31:0] DEF_FIRST_ADDR = 32'h0000_0000;
    localparam logic [31:0] DEF_LAST_ADDR  = 32'h0007_FFFF;

endpackage

// File: rtl/audio_addr_next.sv
// Combinational next-address and window-end detection for one playback step.
module audio_addr_next #(
    parameter int ADDR_W = 32,
    parameter int STEP_W = 4
) (
    input  logic [ADDR_W-1:0] curr_i,
    input  logic [ADDR_W-1:0] lo_i,
    input  logic [ADDR_W-1:0] hi_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              dir_i,
    input  logic              loop_en_i,
    output logic [ADDR_W-1:0] next_o,
    output logic              at_end_o
);
    localparam int AW1 = ADDR_W + 1;

    logic [AW1-1:0] s;
    logic [AW1-1:0] span;
    logic [AW1-1:0] moved;

    // One extra bit keeps the remaining-distance compare free of wraparound.
    always_comb begin
        s = (step_i == '0) ? AW1'(1) : AW1'(step_i);
        if (dir_i) begin
            span  = {1'b0, hi_i} - {1'b0, curr_i};
            moved = {1'b0, curr_i} + s;
        end else begin
            span  = {1'b0, curr_i} - {1'b0, lo_i};
            moved = {1'b0, curr_i} - s;
        end
        at_end_o = (span < s);
        if (!at_end_o)
            next_o = moved[ADDR_W-1:0];
        else if (loop_en_i)
            next_o = dir_i ? lo_i : hi_i;
        else
            next_o = curr_i;
    end

endmodule

// File: rtl/audio_addr_sequencer.sv
// Flash read-address generator for audio playback: FSM, window latch and handshake.
// Optional AUDIO_ADDR_MARKER_EN adds marker_addr/marker_hit compare on each issued address.
module audio_addr_sequencer
    import audio_addr_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                STEP_W     = 4,
    parameter logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(DEF_FIRST_ADDR),
    parameter logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(DEF_LAST_ADDR)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic              increment,
    input  logic              pause,
    input  logic              restart,
    input  logic              loop_en,
    input  logic [STEP_W-1:0] step,
    input  logic [ADDR_W-1:0] range_lo,
    input  logic [ADDR_W-1:0] range_hi,
    input  logic              addr_ready,
    output logic [ADDR_W-1:0] curr_addr,
    output logic              addr_valid,
    output logic              done,
    output logic              overrun,
    output logic              range_err
`ifdef AUDIO_ADDR_MARKER_EN
    ,
    input  logic [ADDR_W-1:0] marker_addr,
    output logic              marker_hit
`endif
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] curr_q, curr_d, lo_q, lo_d, hi_q, hi_d;
    logic              valid_q, valid_d, done_q, done_d;
    logic              ovr_q, ovr_d, rerr_q, rerr_d;
    logic              issue;
    logic [ADDR_W-1:0] nxt;
    logic              at_end;

    audio_addr_next #(.ADDR_W(ADDR_W), .STEP_W(STEP_W)) u_next (
        .curr_i    (curr_q),
        .lo_i      (lo_q),
        .hi_i      (hi_q),
        .step_i    (step),
        .dir_i     (increment),
        .loop_en_i (loop_en),
        .next_o    (nxt),
        .at_end_o  (at_end)
    );

    always_comb begin
        state_d = state_q;
        curr_d  = curr_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        done_d  = done_q;
        ovr_d   = ovr_q;
        rerr_d  = rerr_q;
        issue   = 1'b0;
        if (restart) begin
            if (range_lo > range_hi) begin
                rerr_d = 1'b1;
            end else begin
                lo_d    = range_lo;
                hi_d    = range_hi;
                curr_d  = increment ? range_lo : range_hi;
                done_d  = 1'b0;
                state_d = RUN;
                issue   = 1'b1;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (pause) begin
                        state_d = PAUSED;
                    end else if (sample_tick) begin
                        // A tick is dropped rather than overwriting an unaccepted address.
                        if (valid_q && !addr_ready) begin
                            ovr_d = 1'b1;
                        end else if (at_end && !loop_en) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            curr_d = nxt;
                            issue  = 1'b1;
                        end
                    end
                end
                PAUSED:  if (!pause) state_d = RUN;
                default: ;
            endcase
        end
        valid_d = issue | (valid_q & ~addr_ready);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            curr_q  <= FIRST_ADDR;
            lo_q    <= FIRST_ADDR;
            hi_q    <= LAST_ADDR;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            curr_q  <= curr_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            rerr_q  <= rerr_d;
        end
    end

    assign curr_addr  = curr_q;
    assign addr_valid = valid_q;
    assign done       = done_q;
    assign overrun    = ovr_q;
    assign range_err  = rerr_q;

`ifdef AUDIO_ADDR_MARKER_EN
    logic hit_q;

    // Registered with curr_q so the pulse lines up with the address it flags.
    always_ff @(posedge clk) begin
        if (!reset_n) hit_q <= 1'b0;
        else          hit_q <= issue && (curr_d == marker_addr);
    end

    assign marker_hit = hit_q;
`endif

endmodule
